// File: rtl/f_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : f_fetch_ctrl
// Purpose  : Fetch-stage controller. Owns the fetch PC, issues one
//            instruction-memory request at a time, buffers returned words
//            with their PCs and presents them to the F/D register under a
//            valid/ready handshake. Redirects flush the buffer and cause any
//            in-flight response to be dropped.
// Revision : 1.0 - initial release
// ============================================================================
module f_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        d_ready
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(BUF_DEPTH);
    localparam logic [31:0]      C_PC_ALIGN = {RESET_PC[31:2], 2'b00};

    // REQ: nothing outstanding; WAIT: response will be kept;
    // DROP: response belongs to a flushed path and will be discarded.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t             state_q;
    logic [31:0]        fetch_pc_q;
    logic [31:0]        req_pc_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]        buf_instr_q [BUF_DEPTH];
    logic [31:0]        buf_pc_q    [BUF_DEPTH];
    logic [31:0]        last_instr_q;
    logic [31:0]        last_pc_q;

    logic issue;
    logic push;
    logic pop;

    // Only word-aligned fetch addresses exist; the low bits are ignored.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Requests are held off during reset and whenever the buffer could not
    // absorb the response.
    assign imem_req  = (state_q == S_REQ) && (count_q < C_DEPTH) && !reset;
    assign imem_addr = fetch_pc_q;
    assign issue     = imem_req && imem_gnt;

    // A response arriving together with a redirect is stale and is dropped.
    assign push = (state_q == S_WAIT) && imem_rvalid && !redirect;

    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid && d_ready;

    // When empty, the outputs keep showing the most recent head entry.
    assign instr    = instr_valid ? buf_instr_q[rd_ptr_q] : last_instr_q;
    assign instr_pc = instr_valid ? buf_pc_q[rd_ptr_q]    : last_pc_q;

    // Request sequencer: state, fetch PC and PC of the outstanding request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_REQ;
            fetch_pc_q <= C_PC_ALIGN;
            req_pc_q   <= C_PC_ALIGN;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (issue) begin
                        req_pc_q <= fetch_pc_q;
                        state_q  <= redirect ? S_DROP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_q <= S_REQ;
                    end else if (redirect) begin
                        state_q <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase

            // A redirect always wins over the sequential increment.
            if (redirect) begin
                fetch_pc_q <= {redirect_pc[31:2], 2'b00};
            end else if (issue) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end
        end
    end

    // Buffer bookkeeping: occupancy and wrapping pointers, cleared on redirect.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end
    end

    // Occupancy and pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Buffer storage; entries are only read while the occupancy says valid.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr_q[wr_ptr_q] <= imem_rdata;
            buf_pc_q[wr_ptr_q]    <= req_pc_q;
        end
    end

    // Remember the current head so the outputs stay stable once emptied.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_instr_q <= 32'h0;
            last_pc_q    <= RESET_PC;
        end else if (instr_valid) begin
            last_instr_q <= buf_instr_q[rd_ptr_q];
            last_pc_q    <= buf_pc_q[rd_ptr_q];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_f_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_f_fetch_ctrl
// Purpose  : Directed self-checking bench for f_fetch_ctrl. A simple memory
//            responder grants every request and answers LAT cycles later
//            with data = address ^ 0xFFFF.
// Revision : 1.0 - initial release
// ============================================================================
module tb_f_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        d_ready;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // responder state
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;
    int          lat = 1;

    // delivered instructions, as seen on the handshake
    logic [31:0] pop_pc[$];
    logic [31:0] pop_data[$];
    int          pop_cyc[$];

    f_fetch_ctrl #(
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .d_ready     (d_ready)
    );

    always #5 clk = ~clk;

    // One clock cycle: sample handshakes, cross the edge, drive the response.
    task automatic tick();
        #1;
        if (!reset && imem_req && imem_gnt) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
            pend_cnt  = lat;
        end
        if (!reset && instr_valid && d_ready) begin
            pop_pc.push_back(instr_pc);
            pop_data.push_back(instr);
            pop_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        imem_rvalid = 1'b0;
        if (reset) begin
            pend = 1'b0;
        end else if (pend) begin
            pend_cnt--;
            if (pend_cnt <= 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = pend_addr ^ 32'h0000_FFFF;
                pend        = 1'b0;
            end
        end
    endtask

    task automatic clear_pops();
        pop_pc.delete();
        pop_data.delete();
        pop_cyc.delete();
    endtask

    task automatic do_reset(input bit rdy, input int l);
        reset    = 1'b1;
        redirect = 1'b0;
        imem_gnt = 1'b1;
        d_ready  = rdy;
        lat      = l;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        clear_pops();
    endtask

    task automatic wait_pops(input int n, input string name);
        int k;
        k = 0;
        while (pop_pc.size() < n && k < 60) begin
            tick();
            k++;
        end
        checks++;
        if (pop_pc.size() < n) begin
            errors++;
            $display("FAIL %s_timeout: got %0d deliveries, required %0d", name, pop_pc.size(), n);
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        d_ready     = 1'b1;
        repeat (2) tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b required 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", instr_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h required 0", instr); end
        checks++; if (instr_pc !== RESET_PC) begin errors++; $display("FAIL rst_pc: got %h required %h", instr_pc, RESET_PC); end
        // grant withheld: request and address must hold
        imem_gnt = 1'b0;
        reset    = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
                errors++;
                $display("FAIL stall_hold%0d: got req=%b addr=%h required req=1 addr=%h", i, imem_req, imem_addr, RESET_PC);
            end
            tick();
        end
        imem_gnt = 1'b1;
    endtask

    task automatic test_stream();
        int c0;
        do_reset(1'b1, 1);
        c0 = cyc;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
            errors++; $display("FAIL stream_first_req: got req=%b addr=%h required req=1 addr=00003000", imem_req, imem_addr);
        end
        wait_pops(3, "stream");
        if (pop_pc.size() >= 3) begin
            checks++;
            if (pop_cyc[0] - c0 !== 2) begin errors++; $display("FAIL stream_latency: got %0d required 2", pop_cyc[0] - c0); end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (pop_pc[i] !== 32'h3000 + 32'(4 * i)) begin
                    errors++; $display("FAIL stream_pc%0d: got %h required %h", i, pop_pc[i], 32'h3000 + 32'(4 * i));
                end
                checks++;
                if (pop_data[i] !== ((32'h3000 + 32'(4 * i)) ^ 32'hFFFF)) begin
                    errors++; $display("FAIL stream_data%0d: got %h required %h", i, pop_data[i], (32'h3000 + 32'(4 * i)) ^ 32'hFFFF);
                end
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (pop_cyc[i+1] - pop_cyc[i] !== 2) begin
                    errors++; $display("FAIL stream_gap%0d: got %0d required 2", i, pop_cyc[i+1] - pop_cyc[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0, 1);
        repeat (4) tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_full_req: got %b required 0", imem_req); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_full_valid: got %b required 1", instr_valid); end
        checks++; if (instr_pc !== 32'h3000) begin errors++; $display("FAIL bp_head_pc: got %h required 00003000", instr_pc); end
        checks++; if (instr !== 32'h0000_CFFF) begin errors++; $display("FAIL bp_head_instr: got %h required 0000cfff", instr); end
        repeat (3) tick();
        checks++;
        if (imem_req !== 1'b0 || instr_pc !== 32'h3000) begin
            errors++; $display("FAIL bp_hold: got req=%b pc=%h required req=0 pc=00003000", imem_req, instr_pc);
        end
        d_ready = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h3008) begin
            errors++; $display("FAIL bp_next_req: got req=%b addr=%h required req=1 addr=00003008", imem_req, imem_addr);
        end
        wait_pops(3, "bp");
        if (pop_pc.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (pop_pc[i] !== 32'h3000 + 32'(4 * i)) begin
                    errors++; $display("FAIL bp_order%0d: got %h required %h", i, pop_pc[i], 32'h3000 + 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_redirect_wait();
        do_reset(1'b1, 3);
        tick();                       // grant for 0x3000
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rw_wait_req: got %b required 0", imem_req); end
        redirect    = 1'b1;
        redirect_pc = 32'h4010;
        tick();
        redirect = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL rw_drop: got req=%b valid=%b required req=0 valid=0", imem_req, instr_valid);
        end
        tick();                       // stale response arrives this cycle
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rw_drop_hold: got %b required 0", imem_req); end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4010) begin
            errors++; $display("FAIL rw_new_req: got req=%b addr=%h required req=1 addr=00004010", imem_req, imem_addr);
        end
        wait_pops(1, "rw");
        if (pop_pc.size() >= 1) begin
            checks++;
            if (pop_pc[0] !== 32'h4010 || pop_data[0] !== 32'h0000_BFEF) begin
                errors++; $display("FAIL rw_first: got pc=%h data=%h required pc=00004010 data=0000bfef", pop_pc[0], pop_data[0]);
            end
        end
    endtask

    task automatic test_redirect_gnt();
        int k;
        do_reset(1'b1, 1);
        k = 0;
        while (!(imem_req === 1'b1 && imem_addr === 32'h300C) && k < 30) begin
            tick();
            k++;
        end
        checks++;
        if (k >= 30) begin errors++; $display("FAIL rg_reach_timeout: got addr=%h required 0000300c", imem_addr); end
        redirect    = 1'b1;
        redirect_pc = 32'h5000;
        tick();
        redirect = 1'b0;
        clear_pops();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rg_drop_req: got %b required 0", imem_req); end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h5000) begin
            errors++; $display("FAIL rg_new_req: got req=%b addr=%h required req=1 addr=00005000", imem_req, imem_addr);
        end
        wait_pops(2, "rg");
        if (pop_pc.size() >= 2) begin
            checks++;
            if (pop_pc[0] !== 32'h5000 || pop_data[0] !== 32'h0000_AFFF) begin
                errors++; $display("FAIL rg_first: got pc=%h data=%h required pc=00005000 data=0000afff", pop_pc[0], pop_data[0]);
            end
            checks++;
            if (pop_pc[1] !== 32'h5004 || pop_data[1] !== 32'h0000_AFFB) begin
                errors++; $display("FAIL rg_second: got pc=%h data=%h required pc=00005004 data=0000affb", pop_pc[1], pop_data[1]);
            end
        end
        // unaligned redirect target
        redirect    = 1'b1;
        redirect_pc = 32'h5002;
        tick();
        redirect = 1'b0;
        clear_pops();
        k = 0;
        while (imem_req !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h5000) begin
            errors++; $display("FAIL rg_align: got req=%b addr=%h required req=1 addr=00005000", imem_req, imem_addr);
        end
        wait_pops(1, "rg_align");
        if (pop_pc.size() >= 1) begin
            checks++;
            if (pop_pc[0] !== 32'h5000) begin errors++; $display("FAIL rg_align_pc: got %h required 00005000", pop_pc[0]); end
        end
    endtask

    task automatic test_redirect_full();
        do_reset(1'b0, 1);
        repeat (4) tick();
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL rf_full_valid: got %b required 1", instr_valid); end
        d_ready     = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h6000;
        tick();
        redirect = 1'b0;
        clear_pops();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rf_flush_valid: got %b required 0", instr_valid); end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h6000) begin
            errors++; $display("FAIL rf_new_req: got req=%b addr=%h required req=1 addr=00006000", imem_req, imem_addr);
        end
        checks++; if (instr_pc !== 32'h3000) begin errors++; $display("FAIL rf_hold_pc: got %h required 00003000", instr_pc); end
        wait_pops(1, "rf");
        if (pop_pc.size() >= 1) begin
            checks++;
            if (pop_pc[0] !== 32'h6000) begin errors++; $display("FAIL rf_first: got %h required 00006000", pop_pc[0]); end
        end
    endtask

    task automatic test_reset_mid_wait();
        int k;
        d_ready = 1'b0;
        lat     = 3;
        k = 0;
        while (!(instr_valid === 1'b1 && pend) && k < 30) begin
            tick();
            k++;
        end
        checks++;
        if (k >= 30) begin errors++; $display("FAIL rm_reach_timeout: got valid=%b required 1 with request outstanding", instr_valid); end
        reset = 1'b1;
        tick();
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++; $display("FAIL rm_reset: got valid=%b req=%b required 0 0", instr_valid, imem_req);
        end
        checks++;
        if (instr !== 32'h0 || instr_pc !== RESET_PC) begin
            errors++; $display("FAIL rm_reset_head: got instr=%h pc=%h required 00000000 %h", instr, instr_pc, RESET_PC);
        end
        reset = 1'b0;
        lat   = 1;
        #1;
        clear_pops();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
            errors++; $display("FAIL rm_restart: got req=%b addr=%h required req=1 addr=00003000", imem_req, imem_addr);
        end
        d_ready = 1'b1;
        wait_pops(1, "rm");
        if (pop_pc.size() >= 1) begin
            checks++;
            if (pop_pc[0] !== 32'h3000) begin errors++; $display("FAIL rm_first: got %h required 00003000", pop_pc[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_gnt();
        test_redirect_full();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
